// File: rtl/param_fifo_if.sv
// param_fifo_if: write/read handshake bundle between a FIFO user (master) and param_fifo (slave).
interface param_fifo_if #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 16,
    parameter int HIST_N = 6
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     param_fifo_wr_en;
    logic [DATA_W-1:0]        param_fifo_din;
    logic                     param_fifo_rd_en;
    logic [DATA_W-1:0]        param_fifo_dout;
    logic                     param_fifo_valid;
    logic                     param_fifo_wr_ack;
    logic                     param_fifo_full;
    logic                     param_fifo_empty;
    logic                     param_fifo_afull;
    logic                     param_fifo_aempty;
    logic                     param_fifo_overflow;
    logic                     param_fifo_underflow;
    logic [CW-1:0]            param_fifo_count;
    logic [HIST_N*DATA_W-1:0] param_fifo_hist;

    modport master (
        output param_fifo_wr_en, param_fifo_din, param_fifo_rd_en,
        input  param_fifo_dout, param_fifo_valid, param_fifo_wr_ack,
        input  param_fifo_full, param_fifo_empty, param_fifo_afull,
        input  param_fifo_aempty, param_fifo_overflow, param_fifo_underflow,
        input  param_fifo_count, param_fifo_hist
    );

    modport slave (
        input  param_fifo_wr_en, param_fifo_din, param_fifo_rd_en,
        output param_fifo_dout, param_fifo_valid, param_fifo_wr_ack,
        output param_fifo_full, param_fifo_empty, param_fifo_afull,
        output param_fifo_aempty, param_fifo_overflow, param_fifo_underflow,
        output param_fifo_count, param_fifo_hist
    );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: single-clock FIFO with occupancy flags, error pulses and accepted-write history.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module param_fifo #(
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 16,
    parameter int HIST_N   = 6,
    parameter int AFULL_TH = 14,
    parameter int AEMPT_TH = 2
) (
    input logic          param_fifo_clk,
    input logic          param_fifo_rst,
    param_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = HIST_N * DATA_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_TH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPT_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [HW-1:0]     hist;
    logic              wr_ack;
    logic              overflow;
    logic              underflow;
    logic              full;
    logic              empty;
    logic              wr_ok;
    logic              rd_ok;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    // Acceptance uses the pre-edge flags, so a read never frees room for a same-cycle write.
    assign wr_ok = bus.param_fifo_wr_en & ~full;
    assign rd_ok = bus.param_fifo_rd_en & ~empty;

    always_ff @(posedge param_fifo_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.param_fifo_din;
        end
    end

    always_ff @(posedge param_fifo_clk or posedge param_fifo_rst) begin
        if (param_fifo_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            hist      <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_ok;
            overflow  <= bus.param_fifo_wr_en & full;
            underflow <= bus.param_fifo_rd_en & empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                hist   <= {hist[HW-DATA_W-1:0], bus.param_fifo_din};
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef PARAM_FIFO_FWFT_EN
    // Head word is shown whenever data is present; zero while empty keeps reset output clean.
    assign bus.param_fifo_dout  = empty ? '0 : mem[rd_ptr];
    assign bus.param_fifo_valid = ~empty;
`else
    logic [DATA_W-1:0] dout_q;
    logic              valid_q;

    always_ff @(posedge param_fifo_clk or posedge param_fifo_rst) begin
        if (param_fifo_rst) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_ok;
            if (rd_ok) begin
                dout_q <= mem[rd_ptr];
            end
        end
    end

    assign bus.param_fifo_dout  = dout_q;
    assign bus.param_fifo_valid = valid_q;
`endif

    assign bus.param_fifo_wr_ack    = wr_ack;
    assign bus.param_fifo_full      = full;
    assign bus.param_fifo_empty     = empty;
    assign bus.param_fifo_afull     = (count >= AF_C);
    assign bus.param_fifo_aempty    = (count <= AE_C);
    assign bus.param_fifo_overflow  = overflow;
    assign bus.param_fifo_underflow = underflow;
    assign bus.param_fifo_count     = count;
    assign bus.param_fifo_hist      = hist;
endmodule
